// File: rtl/oc8051_su_gate.sv
// oc8051_su_gate: supervisor call gate with shadow return stack, emitting registered enter/leave SU pulses.
// Events are registered on capture and acted on one edge later, so results appear after the second edge.
module oc8051_su_gate #(
  parameter logic [15:0] SU_BASE = 16'hF000,
  parameter logic [15:0] SU_TOP = 16'hFFFF,
  parameter int ENTRY_ALIGN = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call_valid,
  input  logic [15:0] call_src,
  input  logic [15:0] call_target,
  input  logic [15:0] call_ret,
  input  logic        ret_valid,
  input  logic [15:0] ret_src,
  input  logic [15:0] ret_addr,
  input  logic        viol_clr,
  output logic        enter_su_mode,
  output logic        leave_su_mode,
  output logic [3:0]  su_depth,
  output logic        busy,
  output logic        violation,
  output logic [2:0]  viol_code
);
  localparam logic [3:0] DMAX = 4'(STACK_DEPTH);
  localparam logic [15:0] AMASK = 16'((1 << ENTRY_ALIGN) - 1);
  typedef enum logic [1:0] {RUN, FLUSH, LOCKED} state_t;
  state_t state_q, state_d;
  logic cv_q, rv_q, clr_q, clr_now, push;
  logic [15:0] cs_q, ct_q, cr_q, rs_q, ra_q, top;
  logic [15:0] stk_q [8];
  logic [3:0] depth_q, depth_d;
  logic enter_q, enter_d, leave_q, leave_d, viol_q;
  logic [2:0] code_q, vcode;
  // Offset compare avoids a degenerate compare against the 16-bit maximum.
  function automatic logic in_su(input logic [15:0] a);
    return 16'(a - SU_BASE) <= 16'(SU_TOP - SU_BASE);
  endfunction
  assign top = stk_q[3'(depth_q - 4'd1)];
  assign clr_now = state_q == LOCKED && clr_q;
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    enter_d = 1'b0;
    leave_d = 1'b0;
    push = 1'b0;
    vcode = 3'd0;
    case (state_q)
      RUN: begin
        if (cv_q && rv_q) vcode = 3'd5;
        else if (cv_q && !in_su(cs_q) && in_su(ct_q)) begin
          if ((ct_q & AMASK) != 16'd0) vcode = 3'd1;
          else if (depth_q == DMAX) vcode = 3'd2;
          else begin
            push = 1'b1;
            depth_d = depth_q + 4'd1;
            enter_d = 1'b1;
          end
        end else if (rv_q) begin
          if (depth_q != 4'd0 && ra_q == top && in_su(rs_q)) begin
            depth_d = depth_q - 4'd1;
            leave_d = 1'b1;
          end else if (!in_su(rs_q) && in_su(ra_q) && depth_q == 4'd0) vcode = 3'd3;
          else if (in_su(rs_q) && !in_su(ra_q)) vcode = 3'd4;
        end
        if (vcode != 3'd0) state_d = depth_q != 4'd0 ? FLUSH : LOCKED;
      end
      FLUSH: begin
        if (depth_q != 4'd0) begin
          leave_d = 1'b1;
          depth_d = depth_q - 4'd1;
        end else state_d = LOCKED;
      end
      default: state_d = clr_q ? RUN : state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      depth_q <= 4'd0;
      enter_q <= 1'b0;
      leave_q <= 1'b0;
      viol_q <= 1'b0;
      code_q <= 3'd0;
      cv_q <= 1'b0;
      rv_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      enter_q <= enter_d;
      leave_q <= leave_d;
      cv_q <= call_valid;
      rv_q <= ret_valid;
      clr_q <= viol_clr;
      viol_q <= clr_now ? 1'b0 : viol_q | (vcode != 3'd0);
      code_q <= clr_now ? 3'd0 : (viol_q || vcode == 3'd0) ? code_q : vcode;
    end
  end
  always_ff @(posedge clk) begin
    cs_q <= call_src;
    ct_q <= call_target;
    cr_q <= call_ret;
    rs_q <= ret_src;
    ra_q <= ret_addr;
    if (push) stk_q[depth_q[2:0]] <= cr_q;
  end
  assign enter_su_mode = enter_q;
  assign leave_su_mode = leave_q;
  assign su_depth = depth_q;
  assign busy = state_q == FLUSH;
  assign violation = viol_q;
  assign viol_code = code_q;
endmodule

// File: tb/tb_oc8051_su_gate.sv
// tb_oc8051_su_gate: directed test-plan sequences plus random traffic checked against a queue-based model.
module tb_oc8051_su_gate;
  logic clk = 1'b0, rst = 1'b1;
  logic call_valid, ret_valid, viol_clr;
  logic [15:0] call_src, call_target, call_ret, ret_src, ret_addr;
  logic enter_su_mode, leave_su_mode, busy, violation;
  logic [3:0] su_depth;
  logic [2:0] viol_code;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    bit cv, rv, clr;
    logic [15:0] cs, ct, cr, rs, ra;
  } ev_t;
  ev_t p1, p2;
  logic [15:0] stk [$];
  bit m_flush, m_locked, e_enter, e_leave, e_viol;
  int e_code;
  oc8051_su_gate dut (
    .clk(clk), .rst(rst), .call_valid(call_valid), .call_src(call_src),
    .call_target(call_target), .call_ret(call_ret), .ret_valid(ret_valid),
    .ret_src(ret_src), .ret_addr(ret_addr), .viol_clr(viol_clr),
    .enter_su_mode(enter_su_mode), .leave_su_mode(leave_su_mode), .su_depth(su_depth),
    .busy(busy), .violation(violation), .viol_code(viol_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit insu(input logic [15:0] a);
    return int'(a) >= 'hF000;
  endfunction
  function automatic ev_t idle();
    ev_t e;
    e = '{default: 0};
    return e;
  endfunction
  function automatic ev_t mk_call(input logic [15:0] s, t, r);
    ev_t e = idle();
    e.cv = 1; e.cs = s; e.ct = t; e.cr = r;
    return e;
  endfunction
  function automatic ev_t mk_ret(input logic [15:0] s, a);
    ev_t e = idle();
    e.rv = 1; e.rs = s; e.ra = a;
    return e;
  endfunction
  function automatic ev_t mk_clr();
    ev_t e = idle();
    e.clr = 1;
    return e;
  endfunction
  task automatic model_step(input ev_t e);
    int code = 0;
    e_enter = 0;
    e_leave = 0;
    if (m_flush) begin
      if (stk.size() > 0) begin
        void'(stk.pop_back());
        e_leave = 1;
      end else begin
        m_flush = 0;
        m_locked = 1;
      end
    end else if (m_locked) begin
      if (e.clr) begin
        m_locked = 0;
        e_viol = 0;
        e_code = 0;
      end
    end else begin
      if (e.cv && e.rv) code = 5;
      else if (e.cv) begin
        if (!insu(e.cs) && insu(e.ct)) begin
          if (e.ct % 16 != 0) code = 1;
          else if (stk.size() == 8) code = 2;
          else begin
            stk.push_back(e.cr);
            e_enter = 1;
          end
        end
      end else if (e.rv) begin
        if (stk.size() > 0 && e.ra == stk[$] && insu(e.rs)) begin
          void'(stk.pop_back());
          e_leave = 1;
        end else if (!insu(e.rs) && insu(e.ra) && stk.size() == 0) code = 3;
        else if (insu(e.rs) && !insu(e.ra)) code = 4;
      end
      if (code != 0) begin
        e_viol = 1;
        e_code = code;
        if (stk.size() > 0) m_flush = 1;
        else m_locked = 1;
      end
    end
  endtask
  task automatic drive(input ev_t e);
    call_valid = e.cv; call_src = e.cs; call_target = e.ct; call_ret = e.cr;
    ret_valid = e.rv; ret_src = e.rs; ret_addr = e.ra; viol_clr = e.clr;
  endtask
  task automatic tick(input ev_t e);
    @(negedge clk);
    model_step(p2);
    chk("enter", 16'(enter_su_mode), 16'(e_enter));
    chk("leave", 16'(leave_su_mode), 16'(e_leave));
    chk("depth", 16'(su_depth), 16'(stk.size()));
    chk("busy", 16'(busy), 16'(m_flush));
    chk("violation", 16'(violation), 16'(e_viol));
    chk("code", 16'(viol_code), 16'(e_code));
    p2 = p1;
    p1 = e;
    drive(e);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    drive(idle());
    @(negedge clk);
    chk("rst_enter", 16'(enter_su_mode), 16'd0);
    chk("rst_leave", 16'(leave_su_mode), 16'd0);
    chk("rst_depth", 16'(su_depth), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_viol", 16'(violation), 16'd0);
    chk("rst_code", 16'(viol_code), 16'd0);
    rst = 0;
    stk.delete();
    m_flush = 0; m_locked = 0; e_enter = 0; e_leave = 0; e_viol = 0; e_code = 0;
    p1 = idle();
    p2 = idle();
  endtask
  task automatic idles(input int n);
    for (int i = 0; i < n; i++) tick(idle());
  endtask
  function automatic logic [15:0] usr();
    return 16'($urandom_range(0, 'hEFFF));
  endfunction
  function automatic logic [15:0] sua();
    return 16'($urandom_range('hF000, 'hFFFF));
  endfunction
  function automatic ev_t gen();
    ev_t e;
    int k = $urandom_range(0, 99);
    if (m_flush) return idle();
    if (m_locked) return ($urandom_range(0, 2) == 0) ? mk_clr() : mk_call(usr(), 16'hF000, usr());
    if (k < 35) e = mk_call(usr(), 16'hF000 | (sua() & 16'h0FF0), usr());
    else if (k < 65) e = (stk.size() > 0) ? mk_ret(sua(), stk[$]) : mk_ret(usr(), usr());
    else if (k < 68) e = mk_call(usr(), sua() | 16'h0001, usr());
    else if (k < 78) e = ($urandom_range(0, 1) == 1) ? mk_call(sua(), sua(), sua()) : mk_ret(sua(), sua());
    else if (k < 88) e = ($urandom_range(0, 1) == 1) ? mk_call(usr(), usr(), usr()) : mk_ret(usr(), usr());
    else if (k < 91) e = mk_ret(sua(), usr());
    else if (k < 94) e = mk_ret(usr(), sua());
    else if (k < 96) begin
      e = mk_call(usr(), 16'hF000, usr());
      e.rv = 1; e.rs = sua(); e.ra = usr();
    end else e = idle();
    e.clr = ($urandom_range(0, 15) == 0);
    return e;
  endfunction
  initial begin
    drive(idle());
    p1 = idle();
    p2 = idle();
    do_reset();
    idles(2);
    tick(mk_call(16'h0100, 16'hF040, 16'h0103)); idles(3);
    tick(mk_ret(16'hF0A0, 16'h0103)); idles(3);
    tick(mk_call(16'h0100, 16'hF042, 16'h0103)); idles(3);
    tick(mk_clr()); idles(3);
    for (int i = 0; i < 9; i++) tick(mk_call(16'h0100 + 16'(i), 16'hF000 + 16'(i * 16), 16'h0200 + 16'(i)));
    idles(14);
    tick(mk_clr()); idles(2);
    tick(mk_ret(16'h0200, 16'hF010)); idles(2);
    tick(mk_call(16'h0100, 16'hF040, 16'h0103)); idles(2);
    tick(mk_clr()); idles(2);
    tick(mk_call(16'h0100, 16'hF040, 16'h0103));
    tick(mk_call(16'h0110, 16'hF080, 16'h0113));
    tick(mk_call(16'hF100, 16'hF200, 16'hF103));
    tick(mk_ret(16'hF200, 16'hF103));
    tick(mk_ret(16'hF100, 16'h0500)); idles(6);
    tick(mk_clr()); idles(2);
    tick(mk_call(16'h0100, 16'hF040, 16'h0103)); idles(1);
    begin
      ev_t s = mk_call(16'h0100, 16'hF040, 16'h0105);
      s.rv = 1; s.rs = 16'hF0A0; s.ra = 16'h0105;
      tick(s);
    end
    idles(2);
    chk("flush_busy", 16'(busy), 16'd1);
    do_reset();
    idles(4);
    for (int i = 0; i < 1500; i++) begin
      tick(gen());
      tick(idle());
    end
    idles(12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/oc8051_su_gate.md
Name: oc8051_su_gate

Overview:
- Supervisor-mode call gate for the secure-boot 8051.
- Watches the core's decoded call/return events and decides when control legitimately enters or leaves the supervisor (SU) code region.
- Produces the single-cycle enter_su_mode / leave_su_mode pulses consumed by the privilege-level tracker.
- Keeps a shadow return-address stack so only matching returns drop privilege. Detects gate violations and flushes privilege back to user level.

Parameters:
SU_BASE, 16'hF000, first address of SU code region (inclusive)
SU_TOP, 16'hFFFF, last address of SU code region (inclusive)
ENTRY_ALIGN, 4, number of low call_target bits that must be zero for a legal SU entry point
STACK_DEPTH, 8, shadow return-address stack entries (power of 2, max 8)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
call_valid  input  1  one-cycle pulse: LCALL/ACALL retired
call_src  input  16  PC of the call instruction
call_target  input  16  call destination
call_ret  input  16  return address pushed by the call
ret_valid  input  1  one-cycle pulse: RET/RETI retired
ret_src  input  16  PC of the return instruction
ret_addr  input  16  address popped by the return
viol_clr  input  1  clears sticky violation; honoured only in LOCKED
enter_su_mode  output  1  one-cycle pulse, registered
leave_su_mode  output  1  one-cycle pulse, registered
su_depth  output  4  current shadow stack occupancy
busy  output  1  high in FLUSH
violation  output  1  sticky violation flag
viol_code  output  3  code of the first violation: 0 none, 1 misaligned entry, 2 stack overflow, 3 return into SU at depth 0, 4 escape from SU, 5 call and return in same cycle

Behaviour:
- in(a) is defined as SU_BASE <= a <= SU_TOP, using unsigned 16-bit comparison.
- Reset values: all outputs 0, su_depth 0, state RUN, stack contents don't-care.
- Latency: an event sampled at edge N produces its pulse or violation at the outputs after edge N+1. There is no backpressure, and events arrive at most once per cycle.
- RUN, call_valid only:
  - Gate call is !in(call_src) & in(call_target).
  - If call_target[ENTRY_ALIGN-1:0] != 0: violation code 1.
  - Else if su_depth == STACK_DEPTH: violation code 2.
  - Else: push call_ret, su_depth+1, pulse enter_su_mode.
  - Any other call is ignored.
- RUN, ret_valid only, checked in priority order:
  - (a) If su_depth > 0 and ret_addr == top of stack and in(ret_src): pop, su_depth-1, pulse leave_su_mode.
  - (b) Else if !in(ret_src) & in(ret_addr) & su_depth == 0: violation code 3.
  - (c) Else if in(ret_src) & !in(ret_addr): violation code 4.
  - (d) Else ignored. This covers internal SU returns and user-to-user returns.
- RUN, call_valid & ret_valid in the same cycle: violation code 5, no push or pop.
- On any violation:
  - violation set to 1 and viol_code latched; no pulse is issued for that event.
  - If su_depth > 0, go to FLUSH; else go to LOCKED.
- FLUSH:
  - busy=1.
  - Each cycle: pulse leave_su_mode and decrement su_depth, so leave_su_mode is continuously high for exactly su_depth cycles.
  - When su_depth reaches 0, go to LOCKED on the following cycle.
  - All events and viol_clr are ignored.
- LOCKED:
  - busy=0; all events are ignored, with no pushes, pulses, or new codes.
  - viol_clr=1: violation and viol_code cleared, next state RUN.
- Violation latching: only the first violation is latched. Later events cannot overwrite the code until it is cleared.
- Output exclusivity: enter_su_mode and leave_su_mode are never high in the same cycle.
- Stack bounds: su_depth never exceeds STACK_DEPTH and never wraps below 0.
- Reset mid-FLUSH: state RUN, su_depth 0, no further leave pulses. The tracker is reset by the same rst.

Test Plan:
- Legal gate call then return: call src=0x0100, target=0xF040, ret=0x0103 -> enter_su_mode pulse 1 cycle later, su_depth=1. Then ret src=0xF0A0, addr=0x0103 -> leave_su_mode pulse, su_depth=0, violation=0.
- Misaligned entry: call src=0x0100, target=0xF042 -> no enter pulse, violation=1, viol_code=1, state LOCKED (busy=0). viol_clr -> violation=0, viol_code=0.
- Overflow with STACK_DEPTH=8: 8 legal gate calls -> su_depth=8 and 8 enter pulses. The 9th gate call -> viol_code=2, then 8 consecutive leave pulses with busy=1, then su_depth=0 and LOCKED.
- Return into SU from user at depth 0: ret src=0x0200, addr=0xF010 -> viol_code=3, no leave pulse. Events in LOCKED produce no pulses until viol_clr.
- Escape plus ignored internal traffic: at depth 2, an internal SU call (src 0xF100, target 0xF200) and its return produce no pulses. Then ret src=0xF100, addr=0x0500 (not top) -> viol_code=4, exactly 2 leave pulses.
- Simultaneous call/ret at depth 1 -> viol_code=5, 1 leave pulse. Asserting rst in the FLUSH cycle -> all outputs 0 the next cycle.
